// File: rtl/meter_pkg.sv
// rtl/meter_pkg.sv - shared types and helpers for the band peak meter
// Band count/width, sweep FSM states and a saturating subtract.
package meter_pkg;

  localparam int NUM_BANDS = 7;
  localparam int BAND_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SWEEP  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  typedef logic [2:0] band_idx_t;
  typedef logic [BAND_W-1:0] band_t;

  function automatic band_t sat_sub(input band_t value, input int step);
    int diff;
    diff = int'(value) - step;
    return (diff > 0) ? band_t'(diff) : '0;
  endfunction

endpackage

// File: rtl/band_meter_alu.sv
// rtl/band_meter_alu.sv - combinational single-band level/peak update
// The peak/hold datapath exists only when PEAK_HOLD_EN is defined.
module band_meter_alu
  import meter_pkg::*;
#(
  parameter int LEVEL_STEP = 1
`ifdef PEAK_HOLD_EN
  ,
  parameter int PEAK_STEP = 2,
  parameter int HOLD_SAMPLES = 24000,
  parameter int HOLD_W = 15
`endif
) (
  input  logic              tick,
  input  band_t             in,
  input  band_t             level,
`ifdef PEAK_HOLD_EN
  input  band_t             peak,
  input  logic [HOLD_W-1:0] hold,
  output band_t             peak_new,
  output logic [HOLD_W-1:0] hold_new,
`endif
  output band_t             level_new
);

  band_t level_dec;

  assign level_dec = sat_sub(level, LEVEL_STEP);

  // Fast attack: any input at or above the level is taken at once.
  always_comb begin
    level_new = level;
    if (in >= level) begin
      level_new = in;
    end else if (tick) begin
      level_new = (level_dec > in) ? level_dec : in;
    end
  end

`ifdef PEAK_HOLD_EN
  band_t peak_dec;

  assign peak_dec = sat_sub(peak, PEAK_STEP);

  // Peak decays only after the hold expires, and never below the new level.
  always_comb begin
    peak_new = peak;
    hold_new = hold;
    if (in >= peak) begin
      peak_new = in;
      hold_new = HOLD_W'(HOLD_SAMPLES);
    end else if (hold != '0) begin
      hold_new = hold - HOLD_W'(1);
    end else if (tick) begin
      peak_new = (peak_dec > level_new) ? peak_dec : level_new;
    end
  end
`endif

endmodule

// File: rtl/band_peak_meter.sv
// rtl/band_peak_meter.sv - seven-band decaying level and peak-hold meter
// Serial sweep through one shared ALU; PEAK_HOLD_EN builds the peak-hold path.
module band_peak_meter
  import meter_pkg::*;
#(
  parameter int HOLD_SAMPLES = 24000,
  parameter int DECAY_DIV = 480,
  parameter int LEVEL_STEP = 1,
  parameter int PEAK_STEP = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ready,
  input  logic [BAND_W-1:0] freq1,
  input  logic [BAND_W-1:0] freq2,
  input  logic [BAND_W-1:0] freq3,
  input  logic [BAND_W-1:0] freq4,
  input  logic [BAND_W-1:0] freq5,
  input  logic [BAND_W-1:0] freq6,
  input  logic [BAND_W-1:0] freq7,
  output logic [BAND_W-1:0] level1,
  output logic [BAND_W-1:0] level2,
  output logic [BAND_W-1:0] level3,
  output logic [BAND_W-1:0] level4,
  output logic [BAND_W-1:0] level5,
  output logic [BAND_W-1:0] level6,
  output logic [BAND_W-1:0] level7,
  output logic [BAND_W-1:0] peak1,
  output logic [BAND_W-1:0] peak2,
  output logic [BAND_W-1:0] peak3,
  output logic [BAND_W-1:0] peak4,
  output logic [BAND_W-1:0] peak5,
  output logic [BAND_W-1:0] peak6,
  output logic [BAND_W-1:0] peak7,
  output logic              valid,
  output logic              busy,
  output logic              overrun
);

  localparam int CNT_W = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DECAY_DIV - 1);
  localparam band_idx_t LAST_BAND = band_idx_t'(NUM_BANDS - 1);

  state_t           state;
  band_idx_t        idx;
  logic [CNT_W-1:0] cnt;
  logic             tick;
  band_t            freq_in [NUM_BANDS];
  band_t            snap    [NUM_BANDS];
  band_t            lvl     [NUM_BANDS];
  band_t            lvl_out [NUM_BANDS];
  band_t            alu_level;

`ifdef PEAK_HOLD_EN
  localparam int HOLD_W = $clog2(HOLD_SAMPLES + 1);

  band_t             pk     [NUM_BANDS];
  band_t             pk_out [NUM_BANDS];
  logic [HOLD_W-1:0] hold   [NUM_BANDS];
  band_t             alu_peak;
  logic [HOLD_W-1:0] alu_hold;
`endif

  assign freq_in[0] = freq1;
  assign freq_in[1] = freq2;
  assign freq_in[2] = freq3;
  assign freq_in[3] = freq4;
  assign freq_in[4] = freq5;
  assign freq_in[5] = freq6;
  assign freq_in[6] = freq7;

  band_meter_alu #(
    .LEVEL_STEP  (LEVEL_STEP)
`ifdef PEAK_HOLD_EN
    ,
    .PEAK_STEP   (PEAK_STEP),
    .HOLD_SAMPLES(HOLD_SAMPLES),
    .HOLD_W      (HOLD_W)
`endif
  ) u_alu (
    .tick     (tick),
    .in       (snap[idx]),
    .level    (lvl[idx]),
`ifdef PEAK_HOLD_EN
    .peak     (pk[idx]),
    .hold     (hold[idx]),
    .peak_new (alu_peak),
    .hold_new (alu_hold),
`endif
    .level_new(alu_level)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      idx     <= '0;
      cnt     <= '0;
      tick    <= 1'b0;
      valid   <= 1'b0;
      overrun <= 1'b0;
      for (int i = 0; i < NUM_BANDS; i++) begin
        snap[i]    <= '0;
        lvl[i]     <= '0;
        lvl_out[i] <= '0;
`ifdef PEAK_HOLD_EN
        pk[i]      <= '0;
        pk_out[i]  <= '0;
        hold[i]    <= '0;
`endif
      end
    end else begin
      valid   <= 1'b0;
      overrun <= ready && (state != IDLE);
      case (state)
        IDLE: begin
          if (ready) begin
            for (int i = 0; i < NUM_BANDS; i++) begin
              snap[i] <= freq_in[i];
            end
            // The decay tick belongs to the sample that wraps the divider.
            tick  <= (cnt == CNT_LAST);
            cnt   <= (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
            idx   <= '0;
            state <= SWEEP;
          end
        end
        SWEEP: begin
          lvl[idx] <= alu_level;
`ifdef PEAK_HOLD_EN
          pk[idx]   <= alu_peak;
          hold[idx] <= alu_hold;
`endif
          if (idx == LAST_BAND) begin
            state <= COMMIT;
          end else begin
            idx <= idx + band_idx_t'(1);
          end
        end
        COMMIT: begin
          lvl_out <= lvl;
`ifdef PEAK_HOLD_EN
          pk_out  <= pk;
`endif
          valid   <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

  assign level1 = lvl_out[0];
  assign level2 = lvl_out[1];
  assign level3 = lvl_out[2];
  assign level4 = lvl_out[3];
  assign level5 = lvl_out[4];
  assign level6 = lvl_out[5];
  assign level7 = lvl_out[6];

`ifdef PEAK_HOLD_EN
  assign peak1 = pk_out[0];
  assign peak2 = pk_out[1];
  assign peak3 = pk_out[2];
  assign peak4 = pk_out[3];
  assign peak5 = pk_out[4];
  assign peak6 = pk_out[5];
  assign peak7 = pk_out[6];
`else
  assign peak1 = lvl_out[0];
  assign peak2 = lvl_out[1];
  assign peak3 = lvl_out[2];
  assign peak4 = lvl_out[3];
  assign peak5 = lvl_out[4];
  assign peak6 = lvl_out[5];
  assign peak7 = lvl_out[6];
`endif

endmodule

// File: tb/tb_band_peak_meter.sv
// tb/tb_band_peak_meter.sv - bench for band_peak_meter against a sample-level model
// Two instances: decay divider 4 (a) and 1 (b), both with a 5-sample hold.
module tb_band_peak_meter;

  localparam int HOLD = 5;
  localparam int LSTEP = 1;
  localparam int PSTEP = 2;
`ifdef PEAK_HOLD_EN
  localparam int REL_B_PK = 194;
  localparam int PH5_B_PK = 100;
  localparam int PH6_B_PK = 98;
`else
  localparam int REL_B_PK = 192;
  localparam int PH5_B_PK = 95;
  localparam int PH6_B_PK = 94;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       ready = 1'b0;
  logic [7:0] freq  [7];
  logic [7:0] a_lvl [7];
  logic [7:0] a_pk  [7];
  logic [7:0] b_lvl [7];
  logic [7:0] b_pk  [7];
  logic       a_valid, a_busy, a_ov, b_valid, b_busy, b_ov;

  int checks = 0;
  int errors = 0;
  int n_val = 0;
  int n_ov = 0;

  int div_of [2] = '{4, 1};
  int m_lvl  [2][7];
  int m_pk   [2][7];
  int m_hold [2][7];
  int m_cnt  [2];
  int e_lvl  [2][7];
  int e_pk   [2][7];
  int edge_no = 0;
  int acc = 0;
  bit acc_ok = 1'b0;
  bit e_valid = 1'b0;
  bit e_busy = 1'b0;
  bit e_ov = 1'b0;

  band_peak_meter #(.HOLD_SAMPLES(HOLD), .DECAY_DIV(4), .LEVEL_STEP(LSTEP), .PEAK_STEP(PSTEP)) u_a (
    .clock(clock), .reset(reset), .ready(ready),
    .freq1(freq[0]), .freq2(freq[1]), .freq3(freq[2]), .freq4(freq[3]),
    .freq5(freq[4]), .freq6(freq[5]), .freq7(freq[6]),
    .level1(a_lvl[0]), .level2(a_lvl[1]), .level3(a_lvl[2]), .level4(a_lvl[3]),
    .level5(a_lvl[4]), .level6(a_lvl[5]), .level7(a_lvl[6]),
    .peak1(a_pk[0]), .peak2(a_pk[1]), .peak3(a_pk[2]), .peak4(a_pk[3]),
    .peak5(a_pk[4]), .peak6(a_pk[5]), .peak7(a_pk[6]),
    .valid(a_valid), .busy(a_busy), .overrun(a_ov)
  );

  band_peak_meter #(.HOLD_SAMPLES(HOLD), .DECAY_DIV(1), .LEVEL_STEP(LSTEP), .PEAK_STEP(PSTEP)) u_b (
    .clock(clock), .reset(reset), .ready(ready),
    .freq1(freq[0]), .freq2(freq[1]), .freq3(freq[2]), .freq4(freq[3]),
    .freq5(freq[4]), .freq6(freq[5]), .freq7(freq[6]),
    .level1(b_lvl[0]), .level2(b_lvl[1]), .level3(b_lvl[2]), .level4(b_lvl[3]),
    .level5(b_lvl[4]), .level6(b_lvl[5]), .level7(b_lvl[6]),
    .peak1(b_pk[0]), .peak2(b_pk[1]), .peak3(b_pk[2]), .peak4(b_pk[3]),
    .peak5(b_pk[4]), .peak6(b_pk[5]), .peak7(b_pk[6]),
    .valid(b_valid), .busy(b_busy), .overrun(b_ov)
  );

  initial forever #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
    end
  endtask

  task automatic lit(input string name, input int dut_v, input int model_v, input int want);
    chk({name, "_dut"}, dut_v, want);
    chk({name, "_model"}, model_v, want);
  endtask

  function automatic int max2(input int x, input int y);
    return (x > y) ? x : y;
  endfunction

  // One audio sample applied to both modelled meters.
  task automatic model_accept();
    for (int d = 0; d < 2; d++) begin
      bit tk;
      tk = (m_cnt[d] == div_of[d] - 1);
      m_cnt[d] = (m_cnt[d] + 1) % div_of[d];
      for (int b = 0; b < 7; b++) begin
        int x;
        x = int'(freq[b]);
        if (x >= m_lvl[d][b]) m_lvl[d][b] = x;
        else if (tk) m_lvl[d][b] = max2(x, m_lvl[d][b] - LSTEP);
`ifdef PEAK_HOLD_EN
        if (x >= m_pk[d][b]) begin
          m_pk[d][b] = x;
          m_hold[d][b] = HOLD;
        end else if (m_hold[d][b] > 0) begin
          m_hold[d][b] = m_hold[d][b] - 1;
        end else if (tk) begin
          m_pk[d][b] = max2(m_lvl[d][b], m_pk[d][b] - PSTEP);
        end
`else
        m_pk[d][b] = m_lvl[d][b];
`endif
      end
    end
  endtask

  initial forever begin
    @(posedge clock or negedge reset);
    if (!reset) begin
      acc_ok = 1'b0;
      e_valid = 1'b0;
      e_busy = 1'b0;
      e_ov = 1'b0;
      for (int d = 0; d < 2; d++) begin
        m_cnt[d] = 0;
        for (int b = 0; b < 7; b++) begin
          m_lvl[d][b] = 0; m_pk[d][b] = 0; m_hold[d][b] = 0;
          e_lvl[d][b] = 0; e_pk[d][b] = 0;
        end
      end
    end else begin
      int k;
      e_ov = 1'b0;
      if (ready) begin
        if (!acc_ok || edge_no - acc >= 9) begin
          acc_ok = 1'b1;
          acc = edge_no;
          model_accept();
        end else begin
          e_ov = 1'b1;
        end
      end
      k = edge_no - acc;
      e_busy = acc_ok && k >= 0 && k <= 7;
      e_valid = acc_ok && k == 8;
      if (e_valid) begin
        e_lvl = m_lvl;
        e_pk = m_pk;
      end
      edge_no++;
    end
  end

  initial forever begin
    @(negedge clock);
    chk("a.valid", a_valid, e_valid);
    chk("a.busy", a_busy, e_busy);
    chk("a.overrun", a_ov, e_ov);
    chk("b.valid", b_valid, e_valid);
    chk("b.busy", b_busy, e_busy);
    chk("b.overrun", b_ov, e_ov);
    for (int b = 0; b < 7; b++) begin
      chk($sformatf("a.level%0d", b + 1), a_lvl[b], e_lvl[0][b]);
      chk($sformatf("a.peak%0d", b + 1), a_pk[b], e_pk[0][b]);
      chk($sformatf("b.level%0d", b + 1), b_lvl[b], e_lvl[1][b]);
      chk($sformatf("b.peak%0d", b + 1), b_pk[b], e_pk[1][b]);
    end
    if (a_valid) n_val++;
    if (a_ov) n_ov++;
  end

  task automatic set_freqs(input int b1, input int v1, input int b2, input int v2);
    for (int b = 0; b < 7; b++) freq[b] = 8'd0;
    if (b1 >= 0) freq[b1] = 8'(v1);
    if (b2 >= 0) freq[b2] = 8'(v2);
  endtask

  task automatic sample();
    int n;
    @(negedge clock);
    ready = 1'b1;
    @(negedge clock);
    ready = 1'b0;
    n = 0;
    while (!a_valid && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (!a_valid) chk("valid_timeout", 0, 1);
  endtask

  task automatic do_reset();
    @(negedge clock);
    #2 reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    for (int b = 0; b < 7; b++) freq[b] = 8'd0;
    repeat (3) @(negedge clock);
    chk("rst_busy", a_busy, 0);
    chk("rst_valid", a_valid, 0);
    chk("rst_level3", a_lvl[2], 0);
    chk("rst_peak3", b_pk[2], 0);
    reset = 1'b1;

    set_freqs(-1, 0, -1, 0);
    sample();
    lit("zero_level3", a_lvl[2], e_lvl[0][2], 0);
    lit("zero_peak7", a_pk[6], e_pk[0][6], 0);

    set_freqs(2, 200, -1, 0);
    sample();
    lit("att_level3", a_lvl[2], e_lvl[0][2], 200);
    lit("att_peak3", a_pk[2], e_pk[0][2], 200);
    lit("att_level4", a_lvl[3], e_lvl[0][3], 0);

    set_freqs(-1, 0, -1, 0);
    for (int i = 1; i <= 8; i++) begin
      sample();
      if (i == 1) lit("rel1_level3", a_lvl[2], e_lvl[0][2], 200);
      if (i == 2) lit("rel2_level3", a_lvl[2], e_lvl[0][2], 199);
    end
    lit("rel_level3", a_lvl[2], e_lvl[0][2], 198);
    lit("rel_peak3", a_pk[2], e_pk[0][2], 198);
    lit("rel_b_level3", b_lvl[2], e_lvl[1][2], 192);
    lit("rel_b_peak3", b_pk[2], e_pk[1][2], REL_B_PK);

    do_reset();
    set_freqs(0, 100, -1, 0);
    sample();
    set_freqs(-1, 0, -1, 0);
    for (int i = 1; i <= 11; i++) begin
      sample();
      if (i == 5) begin
        lit("ph5_b_peak1", b_pk[0], e_pk[1][0], PH5_B_PK);
        lit("ph5_b_level1", b_lvl[0], e_lvl[1][0], 95);
      end
      if (i == 6) begin
        lit("ph6_b_peak1", b_pk[0], e_pk[1][0], PH6_B_PK);
        lit("ph6_b_level1", b_lvl[0], e_lvl[1][0], 94);
      end
      if (i == 7) lit("ph7_a_peak1", a_pk[0], e_pk[0][0], 98);
      if (i == 10) lit("ph10_b_peak1", b_pk[0], e_pk[1][0], 90);
      if (i == 11) lit("ph11_b_peak1", b_pk[0], e_pk[1][0], 89);
    end

    set_freqs(1, 50, 6, 255);
    #1;
    n_val = 0;
    n_ov = 0;
    @(negedge clock);
    ready = 1'b1;
    @(negedge clock);
    ready = 1'b0;
    repeat (2) @(negedge clock);
    @(negedge clock);
    set_freqs(1, 7, 4, 99);
    ready = 1'b1;
    @(negedge clock);
    ready = 1'b0;
    chk("ovr_pulse", a_ov, 1);
    repeat (12) @(negedge clock);
    #1;
    chk("ovr_valid_count", n_val, 1);
    chk("ovr_overrun_count", n_ov, 1);
    lit("ovr_level2", a_lvl[1], e_lvl[0][1], 50);
    lit("ovr_level7", a_lvl[6], e_lvl[0][6], 255);
    lit("ovr_level5", a_lvl[4], e_lvl[0][4], 0);
    lit("ovr_peak7", b_pk[6], e_pk[1][6], 255);

    set_freqs(0, 255, 3, 77);
    n_val = 0;
    @(negedge clock);
    ready = 1'b1;
    @(negedge clock);
    ready = 1'b0;
    @(negedge clock);
    @(negedge clock);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_busy", a_busy, 0);
    chk("mid_rst_valid", a_valid, 0);
    chk("mid_rst_level2", a_lvl[1], 0);
    chk("mid_rst_level7", a_lvl[6], 0);
    chk("mid_rst_peak7", b_pk[6], 0);
    @(negedge clock);
    reset = 1'b1;
    repeat (12) @(negedge clock);
    #1;
    chk("mid_rst_no_valid", n_val, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
